alu_reservation_station: RTL and testbench

- Reservation station feeding the integer ALU in the out-of-order core.
- Accepts renamed ALU/branch/jump instructions from the dispatcher and holds them until both operands are available.
- Snoops the ALU and LSB broadcast buses to capture operand values.
- Issues at most one ready instruction per cycle to the ALU using the ALU's enable/operand interface.

---
 rtl/alu_reservation_station.sv | 195 +++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU: holds renamed instructions until
// both operands arrive, snoops the ALU/LSB buses, issues one per cycle.
module alu_reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong,
    input  logic             dispatch_en,
    input  logic [OP_W-1:0]  dispatch_op,
    input  logic [XLEN-1:0]  dispatch_pc,
    input  logic [XLEN-1:0]  dispatch_imm,
    input  logic [ROB_W-1:0] dispatch_rd_rename,
    input  logic [XLEN-1:0]  dispatch_vj,
    input  logic [XLEN-1:0]  dispatch_vk,
    input  logic             dispatch_qj_valid,
    input  logic             dispatch_qk_valid,
    input  logic [ROB_W-1:0] dispatch_qj,
    input  logic [ROB_W-1:0] dispatch_qk,
    output logic             rs_full,
    input  logic             alu_broadcast,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [ROB_W-1:0] alu_out_rd_rename,
    input  logic             lsb_broadcast,
    input  logic [XLEN-1:0]  lsb_result,
    input  logic [ROB_W-1:0] lsb_rd_rename,
    output logic             alu_enable,
    output logic [OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]  alu_instr_pc,
    output logic [XLEN-1:0]  alu_imm,
    output logic [XLEN-1:0]  alu_rs1_value,
    output logic [XLEN-1:0]  alu_rs2_value,
    output logic [ROB_W-1:0] alu_in_rd_rename
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_valid;
    logic [RS_SIZE-1:0] r_qk_valid;
    logic [OP_W-1:0]    r_op  [RS_SIZE];
    logic [XLEN-1:0]    r_pc  [RS_SIZE];
    logic [XLEN-1:0]    r_imm [RS_SIZE];
    logic [XLEN-1:0]    r_vj  [RS_SIZE];
    logic [XLEN-1:0]    r_vk  [RS_SIZE];
    logic [ROB_W-1:0]   r_rd  [RS_SIZE];
    logic [ROB_W-1:0]   r_qj  [RS_SIZE];
    logic [ROB_W-1:0]   r_qk  [RS_SIZE];

    logic               r_alu_enable;
    logic [OP_W-1:0]    r_alu_op;
    logic [XLEN-1:0]    r_alu_pc;
    logic [XLEN-1:0]    r_alu_imm;
    logic [XLEN-1:0]    r_alu_rs1;
    logic [XLEN-1:0]    r_alu_rs2;
    logic [ROB_W-1:0]   r_alu_rd;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_issue_found;
    logic [IDX_W-1:0]   w_issue_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_disp_go;
    logic               w_disp_qj_valid;
    logic               w_disp_qk_valid;
    logic [XLEN-1:0]    w_disp_vj;
    logic [XLEN-1:0]    w_disp_vk;

    // Descending scan leaves the lowest matching index in each selector.
    always_comb begin
        w_ready       = r_busy & ~r_qj_valid & ~r_qk_valid;
        w_issue_found = |w_ready;
        w_issue_idx   = '0;
        w_free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) w_issue_idx = IDX_W'(i);
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign rs_full   = &r_busy;
    assign w_disp_go = dispatch_en && !rs_full;

    // Operands produced in the dispatch cycle are captured on the way in.
    always_comb begin
        w_disp_qj_valid = dispatch_qj_valid;
        w_disp_vj       = dispatch_vj;
        w_disp_qk_valid = dispatch_qk_valid;
        w_disp_vk       = dispatch_vk;
        if (dispatch_qj_valid) begin
            if (alu_broadcast && alu_out_rd_rename == dispatch_qj) begin
                w_disp_qj_valid = 1'b0;
                w_disp_vj       = alu_result;
            end else if (lsb_broadcast && lsb_rd_rename == dispatch_qj) begin
                w_disp_qj_valid = 1'b0;
                w_disp_vj       = lsb_result;
            end
        end
        if (dispatch_qk_valid) begin
            if (alu_broadcast && alu_out_rd_rename == dispatch_qk) begin
                w_disp_qk_valid = 1'b0;
                w_disp_vk       = alu_result;
            end else if (lsb_broadcast && lsb_rd_rename == dispatch_qk) begin
                w_disp_qk_valid = 1'b0;
                w_disp_vk       = lsb_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= '0;
            r_qj_valid   <= '0;
            r_qk_valid   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]  <= '0;
                r_pc[i]  <= '0;
                r_imm[i] <= '0;
                r_vj[i]  <= '0;
                r_vk[i]  <= '0;
                r_rd[i]  <= '0;
                r_qj[i]  <= '0;
                r_qk[i]  <= '0;
            end
            r_alu_enable <= 1'b0;
            r_alu_op     <= '0;
            r_alu_pc     <= '0;
            r_alu_imm    <= '0;
            r_alu_rs1    <= '0;
            r_alu_rs2    <= '0;
            r_alu_rd     <= '0;
        end else if (jump_wrong) begin
            r_busy       <= '0;
            r_alu_enable <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_valid[i]) begin
                    if (alu_broadcast && alu_out_rd_rename == r_qj[i]) begin
                        r_vj[i]       <= alu_result;
                        r_qj_valid[i] <= 1'b0;
                    end else if (lsb_broadcast && lsb_rd_rename == r_qj[i]) begin
                        r_vj[i]       <= lsb_result;
                        r_qj_valid[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_valid[i]) begin
                    if (alu_broadcast && alu_out_rd_rename == r_qk[i]) begin
                        r_vk[i]       <= alu_result;
                        r_qk_valid[i] <= 1'b0;
                    end else if (lsb_broadcast && lsb_rd_rename == r_qk[i]) begin
                        r_vk[i]       <= lsb_result;
                        r_qk_valid[i] <= 1'b0;
                    end
                end
            end
            if (w_disp_go) begin
                r_busy[w_free_idx]     <= 1'b1;
                r_op[w_free_idx]       <= dispatch_op;
                r_pc[w_free_idx]       <= dispatch_pc;
                r_imm[w_free_idx]      <= dispatch_imm;
                r_rd[w_free_idx]       <= dispatch_rd_rename;
                r_vj[w_free_idx]       <= w_disp_vj;
                r_vk[w_free_idx]       <= w_disp_vk;
                r_qj_valid[w_free_idx] <= w_disp_qj_valid;
                r_qk_valid[w_free_idx] <= w_disp_qk_valid;
                r_qj[w_free_idx]       <= dispatch_qj;
                r_qk[w_free_idx]       <= dispatch_qk;
            end
            if (w_issue_found) begin
                r_alu_enable        <= 1'b1;
                r_alu_op            <= r_op[w_issue_idx];
                r_alu_pc            <= r_pc[w_issue_idx];
                r_alu_imm           <= r_imm[w_issue_idx];
                r_alu_rs1           <= r_vj[w_issue_idx];
                r_alu_rs2           <= r_vk[w_issue_idx];
                r_alu_rd            <= r_rd[w_issue_idx];
                r_busy[w_issue_idx] <= 1'b0;
            end else begin
                r_alu_enable <= 1'b0;
            end
        end
    end

    assign alu_enable       = r_alu_enable;
    assign alu_op           = r_alu_op;
    assign alu_instr_pc     = r_alu_pc;
    assign alu_imm          = r_alu_imm;
    assign alu_rs1_value    = r_alu_rs1;
    assign alu_rs2_value    = r_alu_rs2;
    assign alu_in_rd_rename = r_alu_rd;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus random traffic,
// every cycle compared against a queue-free behavioural entry model.
module tb_alu_reservation_station;

    localparam int RS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_wrong;
    logic        dispatch_en;
    logic [5:0]  dispatch_op;
    logic [31:0] dispatch_pc;
    logic [31:0] dispatch_imm;
    logic [3:0]  dispatch_rd_rename;
    logic [31:0] dispatch_vj;
    logic [31:0] dispatch_vk;
    logic        dispatch_qj_valid;
    logic        dispatch_qk_valid;
    logic [3:0]  dispatch_qj;
    logic [3:0]  dispatch_qk;
    logic        rs_full;
    logic        alu_broadcast;
    logic [31:0] alu_result;
    logic [3:0]  alu_out_rd_rename;
    logic        lsb_broadcast;
    logic [31:0] lsb_result;
    logic [3:0]  lsb_rd_rename;
    logic        alu_enable;
    logic [5:0]  alu_op;
    logic [31:0] alu_instr_pc;
    logic [31:0] alu_imm;
    logic [31:0] alu_rs1_value;
    logic [31:0] alu_rs2_value;
    logic [3:0]  alu_in_rd_rename;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .dispatch_en(dispatch_en), .dispatch_op(dispatch_op),
        .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
        .dispatch_rd_rename(dispatch_rd_rename),
        .dispatch_vj(dispatch_vj), .dispatch_vk(dispatch_vk),
        .dispatch_qj_valid(dispatch_qj_valid),
        .dispatch_qk_valid(dispatch_qk_valid),
        .dispatch_qj(dispatch_qj), .dispatch_qk(dispatch_qk),
        .rs_full(rs_full),
        .alu_broadcast(alu_broadcast), .alu_result(alu_result),
        .alu_out_rd_rename(alu_out_rd_rename),
        .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result),
        .lsb_rd_rename(lsb_rd_rename),
        .alu_enable(alu_enable), .alu_op(alu_op),
        .alu_instr_pc(alu_instr_pc), .alu_imm(alu_imm),
        .alu_rs1_value(alu_rs1_value), .alu_rs2_value(alu_rs2_value),
        .alu_in_rd_rename(alu_in_rd_rename)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] pc, imm, vj, vk;
        logic [3:0]  rd, qj, qk;
        logic        qjv, qkv;
    } ent_t;

    ent_t        m_rs [RS];
    logic        m_en;
    logic [5:0]  m_op;
    logic [31:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [3:0]  m_rd;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < RS; i++) if (m_rs[i].busy) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RS; i++) begin
            m_rs[i] = '{default: '0};
        end
        m_en = 0; m_op = 0; m_pc = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    endtask

    // Resolve one operand against the two result buses (ALU bus first).
    task automatic snoop(inout logic qv, input logic [3:0] q,
                         inout logic [31:0] v);
        if (!qv) return;
        if (alu_broadcast && alu_out_rd_rename == q) begin
            v = alu_result; qv = 0;
        end else if (lsb_broadcast && lsb_rd_rename == q) begin
            v = lsb_result; qv = 0;
        end
    endtask

    task automatic model_step();
        int   isel = -1;
        int   fsel = -1;
        logic full;
        ent_t e;
        if (jump_wrong) begin
            for (int i = 0; i < RS; i++) m_rs[i].busy = 0;
            m_en = 0;
            return;
        end
        if (!rdy) return;
        full = (m_count() == RS);
        for (int i = 0; i < RS; i++) begin
            if (isel < 0 && m_rs[i].busy && !m_rs[i].qjv && !m_rs[i].qkv)
                isel = i;
            if (fsel < 0 && !m_rs[i].busy) fsel = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (m_rs[i].busy) begin
                snoop(m_rs[i].qjv, m_rs[i].qj, m_rs[i].vj);
                snoop(m_rs[i].qkv, m_rs[i].qk, m_rs[i].vk);
            end
        end
        if (dispatch_en && !full) begin
            e.busy = 1; e.op = dispatch_op; e.pc = dispatch_pc;
            e.imm = dispatch_imm; e.rd = dispatch_rd_rename;
            e.vj = dispatch_vj; e.vk = dispatch_vk;
            e.qjv = dispatch_qj_valid; e.qkv = dispatch_qk_valid;
            e.qj = dispatch_qj; e.qk = dispatch_qk;
            snoop(e.qjv, e.qj, e.vj);
            snoop(e.qkv, e.qk, e.vk);
            m_rs[fsel] = e;
        end
        if (isel >= 0) begin
            m_en = 1; m_op = m_rs[isel].op; m_pc = m_rs[isel].pc;
            m_imm = m_rs[isel].imm; m_rs1 = m_rs[isel].vj;
            m_rs2 = m_rs[isel].vk; m_rd = m_rs[isel].rd;
            m_rs[isel].busy = 0;
        end else begin
            m_en = 0;
        end
    endtask

    task automatic compare_all();
        chk("alu_enable", 32'(alu_enable), 32'(m_en));
        chk("rs_full", 32'(rs_full), 32'(m_count() == RS));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("alu_instr_pc", alu_instr_pc, m_pc);
        chk("alu_imm", alu_imm, m_imm);
        chk("alu_rs1", alu_rs1_value, m_rs1);
        chk("alu_rs2", alu_rs2_value, m_rs2);
        chk("alu_rd", 32'(alu_in_rd_rename), 32'(m_rd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        rdy = 1; jump_wrong = 0; dispatch_en = 0;
        alu_broadcast = 0; lsb_broadcast = 0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [3:0] rd,
                        input logic [31:0] vj, input logic qjv,
                        input logic [3:0] qj, input logic [31:0] vk,
                        input logic qkv, input logic [3:0] qk);
        dispatch_en = 1; dispatch_op = op; dispatch_pc = pc;
        dispatch_imm = imm; dispatch_rd_rename = rd;
        dispatch_vj = vj; dispatch_qj_valid = qjv; dispatch_qj = qj;
        dispatch_vk = vk; dispatch_qk_valid = qkv; dispatch_qk = qk;
    endtask

    initial begin
        rst = 0;
        idle();
        disp(6'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dispatch_en = 0;
        alu_result = 0; alu_out_rd_rename = 0;
        lsb_result = 0; lsb_rd_rename = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1;

        // Ready instruction: dispatched cycle 0, on the ALU in cycle 2
        disp(6'h01, 32'h100, 3, 2, 5, 0, 0, 0, 0, 0);
        tick();
        idle();
        chk("t1_c1_en", 32'(alu_enable), 0);
        tick();
        chk("t1_en", 32'(alu_enable), 1);
        chk("t1_rs1", alu_rs1_value, 5);
        chk("t1_imm", alu_imm, 3);
        chk("t1_rd", 32'(alu_in_rd_rename), 2);
        tick();
        chk("t1_c3_en", 32'(alu_enable), 0);

        // Wakeup via the ALU bus in cycle 4
        disp(6'h02, 32'h104, 0, 5, 0, 1, 7, 10, 0, 0);
        tick();
        idle();
        tick();
        tick();
        chk("t2_c3_en", 32'(alu_enable), 0);
        alu_broadcast = 1; alu_out_rd_rename = 7; alu_result = 32'h20;
        tick();
        idle();
        chk("t2_c5_en", 32'(alu_enable), 0);
        tick();
        chk("t2_en", 32'(alu_enable), 1);
        chk("t2_rs1", alu_rs1_value, 32'h20);
        chk("t2_rs2", alu_rs2_value, 10);
        tick();

        // Bypass from the LSB bus in the dispatch cycle
        disp(6'h03, 32'h108, 0, 6, 1, 0, 0, 0, 1, 3);
        lsb_broadcast = 1; lsb_rd_rename = 3; lsb_result = 32'hFFFF_FFFF;
        tick();
        idle();
        tick();
        chk("t3_en", 32'(alu_enable), 1);
        chk("t3_rs2", alu_rs2_value, 32'hFFFF_FFFF);
        tick();

        // Fill all entries; entries 4 and 9 share a producer tag
        for (int i = 0; i < RS; i++) begin
            disp(6'h04, 32'(i * 4), 0, 4'(i), 0, 1,
                 (i == 4 || i == 9) ? 4'd12 : 4'd13, 0, 0, 0);
            tick();
        end
        idle();
        chk("t4_full", 32'(rs_full), 1);
        disp(6'h05, 32'h200, 0, 15, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        chk("t4_full_after_extra", 32'(rs_full), 1);
        chk("t4_no_issue", 32'(alu_enable), 0);
        alu_broadcast = 1; alu_out_rd_rename = 12; alu_result = 32'hAB;
        tick();
        idle();
        tick();
        chk("t4_first_en", 32'(alu_enable), 1);
        chk("t4_first_rd", 32'(alu_in_rd_rename), 4);
        chk("t4_full_cleared", 32'(rs_full), 0);
        tick();
        chk("t4_second_rd", 32'(alu_in_rd_rename), 9);
        tick();
        chk("t4_done_en", 32'(alu_enable), 0);
        jump_wrong = 1;
        tick();
        idle();

        // Flush with five busy entries and a same-cycle dispatch
        for (int i = 0; i < 5; i++) begin
            disp(6'h06, 0, 0, 4'(i), 0, 1, 13, 0, 0, 0);
            tick();
        end
        disp(6'h07, 0, 0, 8, 1, 0, 0, 2, 0, 0);
        jump_wrong = 1;
        tick();
        idle();
        chk("t5_en", 32'(alu_enable), 0);
        chk("t5_full", 32'(rs_full), 0);
        alu_broadcast = 1; alu_out_rd_rename = 13; alu_result = 1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_issue", 32'(alu_enable), 0);
        end

        // rdy low freezes an issue in flight
        disp(6'h08, 32'h300, 0, 10, 1, 0, 0, 2, 0, 0);
        tick();
        disp(6'h09, 32'h304, 0, 11, 3, 0, 0, 4, 0, 0);
        tick();
        idle();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_en", 32'(alu_enable), 1);
            chk("t6_hold_rd", 32'(alu_in_rd_rename), 10);
        end
        rdy = 1;
        tick();
        chk("t6_next_rd", 32'(alu_in_rd_rename), 11);

        // Asynchronous reset mid-cycle with an issue on the outputs
        disp(6'h0A, 32'h400, 0, 12, 1, 0, 0, 1, 0, 0);
        tick();
        idle();
        tick();
        chk("t6_pre_rst_en", 32'(alu_enable), 1);
        #2;
        rst = 0;
        #1;
        chk("t6_async_en", 32'(alu_enable), 0);
        m_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy = ($urandom_range(7) != 0);
            jump_wrong = ($urandom_range(99) == 0);
            if (m_count() < RS && $urandom_range(1) == 1)
                disp(6'($urandom), $urandom, $urandom, 4'($urandom),
                     $urandom, 1'($urandom), 4'($urandom),
                     $urandom, 1'($urandom), 4'($urandom));
            alu_broadcast = 1'($urandom);
            alu_out_rd_rename = 4'($urandom);
            alu_result = $urandom;
            lsb_broadcast = 1'($urandom);
            lsb_rd_rename = 4'($urandom);
            lsb_result = $urandom;
            if (alu_broadcast && lsb_rd_rename == alu_out_rd_rename)
                lsb_broadcast = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
